// File: rtl/blink_pkg.sv
// Shared types and the blink timing preset table.
// Per-group on/off times are in milliseconds.
package blink_pkg;

  typedef struct packed {
    logic [15:0] on_ms;
    logic [15:0] off_ms;
  } grp_t;

  typedef struct packed {
    grp_t g1;
    grp_t g2;
    grp_t g3;
  } mode_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PENDING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  localparam mode_t PRESETS [4] = '{
    '{'{16'd500, 16'd500}, '{16'd200, 16'd800}, '{16'd100, 16'd100}},
    '{'{16'd250, 16'd250}, '{16'd100, 16'd400}, '{16'd50, 16'd50}},
    '{'{16'd100, 16'd900}, '{16'd500, 16'd500}, '{16'd0, 16'd1000}},
    '{'{16'd1000, 16'd0}, '{16'd50, 16'd50}, '{16'd25, 16'd75}}
  };

  function automatic int unsigned grp_ms(grp_t g);
    return int'(g.on_ms) + int'(g.off_ms);
  endfunction

  function automatic int unsigned max_period_ms();
    int unsigned m;
    m = 0;
    for (int i = 0; i < 4; i++) begin
      if (grp_ms(PRESETS[i].g1) > m) m = grp_ms(PRESETS[i].g1);
      if (grp_ms(PRESETS[i].g2) > m) m = grp_ms(PRESETS[i].g2);
      if (grp_ms(PRESETS[i].g3) > m) m = grp_ms(PRESETS[i].g3);
    end
    return m;
  endfunction

endpackage

// File: rtl/blink_mode_ctrl_if.sv
// Button/switch inputs and LED outputs of the blink controller.
// master drives the requests, slave is the controller.
interface blink_mode_ctrl_if;
  logic       btn_next;
  logic       pause;
  logic       led;
  logic [8:0] q;
  logic [1:0] mode;
  logic       pending;

  modport master (
    output btn_next, pause,
    input  led, q, mode, pending
  );

  modport slave (
    input  btn_next, pause,
    output led, q, mode, pending
  );
endinterface

// File: rtl/blink_wave_gen.sv
// One blink group: period counter plus on-time compare.
// clear zeroes the counter, freeze holds it and blanks the wave.
module blink_wave_gen #(
  parameter int CNT_W = 10,
  parameter int TK_W  = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            freeze,
  input  logic [TK_W-1:0] on_tks,
  input  logic [TK_W-1:0] period,
  output logic            wave,
  output logic            wrap
);

  logic [CNT_W-1:0] cnt_q;
  logic [TK_W-1:0]  cnt_x;
  logic             at_end;

  assign cnt_x  = TK_W'(cnt_q);
  assign at_end = (period == '0)
                | (cnt_x == period - TK_W'(1));
  assign wrap   = ~freeze & at_end;
  assign wave   = ~freeze & (cnt_x < on_tks);

  // count 0..period-1, hold when frozen, zero on clear
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (clear)
      cnt_q <= '0;
    else if (!freeze)
      cnt_q <= at_end ? '0 : cnt_q + CNT_W'(1);
  end

endmodule

// File: rtl/blink_mode_ctrl.sv
// Blink mode controller: preset stepping, glitch-free apply, pause.
// Option BLINK_PHASE_LOCK_EN: zero groups 2/3 on every group-1 wrap.
module blink_mode_ctrl
  import blink_pkg::*;
#(
  parameter int F_CLK_HZ  = 25_000_000,
  parameter int NUM_MODES = 4
) (
  input  logic               clk,
  input  logic               rst,
  blink_mode_ctrl_if.slave   bus
);

  localparam int TICKS_PER_MS = F_CLK_HZ / 1000;
  localparam int MAX_TKS =
    TICKS_PER_MS * int'(max_period_ms());
  localparam int CNT_W =
    (MAX_TKS > 1) ? $clog2(MAX_TKS) : 1;
  localparam int TK_W = CNT_W + 1;

  function automatic logic [TK_W-1:0] tks(
    logic [15:0] ms
  );
    return TK_W'(TICKS_PER_MS * int'(ms));
  endfunction

  function automatic logic [1:0] inc(logic [1:0] m);
    return (int'(m) + 1 >= NUM_MODES)
      ? 2'd0 : m + 2'd1;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  tgt_q, tgt_d;
  logic        pend_q, pend_d;
  logic        pend_now;
  logic        btn_s, btn_p, rise;
  logic        apply, lock, clr23;
  logic        wave1, wave2, wave3;
  logic        wrap1, wrap2, wrap3;
  logic        unused_wrap;
  mode_t       cur;
  logic [TK_W-1:0] on1, on2, on3;
  logic [TK_W-1:0] per1, per2, per3;

  assign cur  = PRESETS[mode_q];
  assign on1  = tks(cur.g1.on_ms);
  assign on2  = tks(cur.g2.on_ms);
  assign on3  = tks(cur.g3.on_ms);
  assign per1 = on1 + tks(cur.g1.off_ms);
  assign per2 = on2 + tks(cur.g2.off_ms);
  assign per3 = on3 + tks(cur.g3.off_ms);

  // two-stage sample of the button level for rise detect
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s <= 1'b0;
      btn_p <= 1'b0;
    end else begin
      btn_s <= bus.btn_next;
      btn_p <= btn_s;
    end
  end

  assign rise = btn_s & ~btn_p;

  // control state: fsm, active mode, queued target
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      mode_q  <= 2'd0;
      tgt_q   <= 2'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
    end
  end

  // next state; a rise during apply advances from the new mode
  always_comb begin
    mode_d = apply ? tgt_q : mode_q;
    tgt_d  = rise ? inc(pend_q ? tgt_q : mode_q)
                  : tgt_q;
    pend_d = apply ? rise : (pend_q | rise);
    if (bus.pause)
      state_d = PAUSED;
    else if (pend_d)
      state_d = PENDING;
    else
      state_d = RUN;
  end

  // fsm outputs: pending flag and apply strobe
  always_comb begin
    unique case (state_q)
      PENDING: pend_now = 1'b1;
      PAUSED:  pend_now = pend_q;
      default: pend_now = 1'b0;
    endcase
    apply = pend_q & wrap1;
  end

`ifdef BLINK_PHASE_LOCK_EN
  assign lock = wrap1;
`else
  assign lock = 1'b0;
`endif

  assign clr23 = apply | lock;

  blink_wave_gen #(.CNT_W(CNT_W), .TK_W(TK_W)) u_g1 (
    .clk(clk), .rst(rst), .clear(apply),
    .freeze(bus.pause), .on_tks(on1), .period(per1),
    .wave(wave1), .wrap(wrap1)
  );

  blink_wave_gen #(.CNT_W(CNT_W), .TK_W(TK_W)) u_g2 (
    .clk(clk), .rst(rst), .clear(clr23),
    .freeze(bus.pause), .on_tks(on2), .period(per2),
    .wave(wave2), .wrap(wrap2)
  );

  blink_wave_gen #(.CNT_W(CNT_W), .TK_W(TK_W)) u_g3 (
    .clk(clk), .rst(rst), .clear(clr23),
    .freeze(bus.pause), .on_tks(on3), .period(per3),
    .wave(wave3), .wrap(wrap3)
  );

  assign unused_wrap = wrap2 ^ wrap3;

  assign bus.led     = wave1;
  assign bus.q       = {{3{wave1}}, {3{wave2}}, {3{wave3}}};
  assign bus.mode    = mode_q;
  assign bus.pending = pend_now;

endmodule

// File: tb/tb_blink_mode_ctrl.sv
// Bench for blink_mode_ctrl at 1 tick per ms.
// Directed literal checks plus random stimulus against a model.
module tb_blink_mode_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  blink_mode_ctrl_if bus ();

  blink_mode_ctrl #(.F_CLK_HZ(1000), .NUM_MODES(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int ON_MS [4][3] = '{
    '{500, 200, 100}, '{250, 100, 50},
    '{100, 500, 0},   '{1000, 50, 25}
  };
  int OFF_MS [4][3] = '{
    '{500, 800, 100}, '{250, 400, 50},
    '{900, 500, 1000}, '{0, 50, 75}
  };
  localparam int NM = 4;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int m_pos [3];
  int m_mode, m_tgt;
  bit m_pend, m_b1, m_b0;
  bit m_ok = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] got,
                              input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d",
               nm, got, want, cyc);
    end
  endfunction

  function automatic int per(int md, int g);
    return ON_MS[md][g] + OFF_MS[md][g];
  endfunction

  // reference model, advanced once per clock
  always @(posedge clk) begin
    bit rise, w1, ap;
    if (rst) begin
      for (int g = 0; g < 3; g++) m_pos[g] = 0;
      m_mode = 0; m_tgt = 0; m_pend = 0;
      m_b0 = 0; m_b1 = 0; cyc = 0; m_ok = 1;
    end else begin
      rise = m_b1 && !m_b0;
      w1 = !bus.pause && (per(m_mode, 0) == 0 ||
           m_pos[0] == per(m_mode, 0) - 1);
      ap = m_pend && w1;
      if (ap) begin
        m_mode = m_tgt;
        for (int g = 0; g < 3; g++) m_pos[g] = 0;
        m_pend = rise;
        if (rise) m_tgt = (m_tgt + 1) % NM;
      end else begin
        if (rise) m_tgt = ((m_pend ? m_tgt : m_mode) + 1) % NM;
        m_pend = m_pend | rise;
        if (!bus.pause)
          for (int g = 0; g < 3; g++)
            m_pos[g] = (per(m_mode, g) == 0) ? 0
                     : (m_pos[g] + 1) % per(m_mode, g);
`ifdef BLINK_PHASE_LOCK_EN
        if (w1) begin m_pos[1] = 0; m_pos[2] = 0; end
`endif
      end
      m_b0 = m_b1;
      m_b1 = bus.btn_next;
      cyc++;
    end
  end

  // per-cycle compare of every output against the model
  always @(negedge clk) begin
    logic [2:0] w;
    if (m_ok) begin
      for (int g = 0; g < 3; g++)
        w[g] = !bus.pause && (m_pos[g] < ON_MS[m_mode][g]);
      chk("m_led", bus.led, w[0]);
      chk("m_q", bus.q, {{3{w[0]}}, {3{w[1]}}, {3{w[2]}}});
      chk("m_mode", bus.mode, m_mode);
      chk("m_pend", bus.pending, m_pend);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic to_cycle(int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.btn_next = 1'b0;
    bus.pause = 1'b0;

    // free run in mode 0
    do_reset();
    chk("t1_led0", bus.led, 1);
    chk("t1_q0", bus.q, 9'h1FF);
    chk("t1_pend0", bus.pending, 0);
    to_cycle(99);   chk("t1_g3_99", bus.q[2:0], 3'h7);
    to_cycle(100);  chk("t1_g3_100", bus.q[2:0], 3'h0);
    to_cycle(199);  chk("t1_g2_199", bus.q[5:3], 3'h7);
    to_cycle(200);  chk("t1_g2_200", bus.q[5:3], 3'h0);
    chk("t1_g3_200", bus.q[2:0], 3'h7);
    to_cycle(499);  chk("t1_led499", bus.led, 1);
    to_cycle(500);  chk("t1_led500", bus.led, 0);
    to_cycle(999);  chk("t1_led999", bus.led, 0);
    to_cycle(1000); chk("t1_led1000", bus.led, 1);
    to_cycle(1999); chk("t1_mode", bus.mode, 0);

    // single press, applied at the group-1 wrap
    do_reset();
    to_cycle(300);  bus.btn_next = 1'b1;
    to_cycle(301);  chk("t2_pend301", bus.pending, 0);
    to_cycle(302);  chk("t2_pend302", bus.pending, 1);
    to_cycle(320);  bus.btn_next = 1'b0;
    to_cycle(999);  chk("t2_mode999", bus.mode, 0);
    chk("t2_pend999", bus.pending, 1);
    to_cycle(1000); chk("t2_mode1000", bus.mode, 1);
    chk("t2_pend1000", bus.pending, 0);
    chk("t2_led1000", bus.led, 1);
    to_cycle(1249); chk("t2_led1249", bus.led, 1);
    to_cycle(1250); chk("t2_led1250", bus.led, 0);
    to_cycle(1500); chk("t2_led1500", bus.led, 1);

    // three presses while pending -> mode 3
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      to_cycle(100 * k);     bus.btn_next = 1'b1;
      to_cycle(100 * k + 5); bus.btn_next = 1'b0;
    end
    to_cycle(999);  chk("t3_pend999", bus.pending, 1);
    to_cycle(1000); chk("t3_mode", bus.mode, 3);
    chk("t3_led1000", bus.led, 1);
    chk("t3_g3_1000", bus.q[2:0], 3'h7);
    to_cycle(1024); chk("t3_g3_1024", bus.q[2:0], 3'h7);
    to_cycle(1025); chk("t3_g3_1025", bus.q[2:0], 3'h0);
    to_cycle(1100); chk("t3_g3_1100", bus.q[2:0], 3'h7);
    to_cycle(1999); chk("t3_led1999", bus.led, 1);

    // pause mid-ON, remaining ON time preserved
    do_reset();
    to_cycle(100);  bus.pause = 1'b1;
    to_cycle(101);  chk("t4_q101", bus.q, 9'h000);
    to_cycle(150);  chk("t4_q150", bus.q, 9'h000);
    to_cycle(200);  bus.pause = 1'b0;
    to_cycle(201);  chk("t4_led201", bus.led, 1);
    to_cycle(300);  chk("t4_g3_300", bus.q[2:0], 3'h7);
    to_cycle(599);  chk("t4_led599", bus.led, 1);
    to_cycle(600);  chk("t4_led600", bus.led, 0);

    // reset while pending in mode 2
    do_reset();
    for (int k = 1; k <= 2; k++) begin
      to_cycle(100 * k);     bus.btn_next = 1'b1;
      to_cycle(100 * k + 5); bus.btn_next = 1'b0;
    end
    to_cycle(1000); chk("t5_mode2", bus.mode, 2);
    to_cycle(1100); bus.btn_next = 1'b1;
    to_cycle(1102); chk("t5_pend", bus.pending, 1);
    to_cycle(1105); bus.btn_next = 1'b0;
    to_cycle(1200);
    do_reset();
    chk("t5_mode_rst", bus.mode, 0);
    chk("t5_pend_rst", bus.pending, 0);
    chk("t5_led_rst", bus.led, 1);

    // random button, pause and occasional reset
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 4999) == 0);
      if ($urandom_range(0, 39) == 0)
        bus.btn_next = ~bus.btn_next;
      if ($urandom_range(0, 299) == 0)
        bus.pause = ~bus.pause;
    end
    rst = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
